// File: rtl/gpu_launch_ctrl.sv
// Kernel launch sequencer in front of the gpu top: reset, DCR program, run, report.
// Optional macro LAUNCH_CYCLE_COUNTER_EN builds the status_cycles run counter.
module gpu_launch_ctrl #(
  parameter int unsigned THREAD_COUNT_BITS = 8,
  parameter int unsigned RESET_CYCLES      = 2,
  parameter int unsigned WATCHDOG_CYCLES   = 65535,
  parameter int unsigned CYCLE_BITS        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         launch_valid,
  output logic                         launch_ready,
  input  logic [THREAD_COUNT_BITS-1:0] launch_thread_count,
  output logic                         gpu_reset,
  output logic                         device_control_write_enable,
  output logic [THREAD_COUNT_BITS-1:0] device_control_data,
  output logic                         gpu_start,
  input  logic                         gpu_done,
  output logic                         status_busy,
  output logic                         status_valid,
  input  logic                         status_ready,
  output logic                         status_timeout,
  output logic [CYCLE_BITS-1:0]        status_cycles
);

  localparam int unsigned RST_BITS = $clog2(RESET_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_DCR    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]                   r_state;
  logic [RST_BITS-1:0]          r_rst_cnt;
  logic [THREAD_COUNT_BITS-1:0] r_count;
  logic                         r_launch_ready;
  logic                         r_gpu_reset;
  logic                         r_dcr_we;
  logic [THREAD_COUNT_BITS-1:0] r_dcr_data;
  logic                         r_gpu_start;
  logic                         r_busy;
  logic                         r_status_valid;
  logic                         r_timeout;

  logic [2:0]                   w_state_nxt;
  logic [RST_BITS-1:0]          w_rst_cnt_nxt;
  logic [THREAD_COUNT_BITS-1:0] w_count_nxt;
  logic                         w_timeout_nxt;
  logic                         w_kill_pulse;
  logic                         w_gpu_reset_nxt;
  logic                         w_dcr_we_nxt;
  logic [THREAD_COUNT_BITS-1:0] w_dcr_data_nxt;
  logic                         w_accept;
  logic                         w_wd_hit;

  assign w_accept = (r_state == S_IDLE) && launch_valid && r_launch_ready;

  // Watchdog: expires on the RUN cycle that brings the count to WATCHDOG_CYCLES
  if (WATCHDOG_CYCLES != 0) begin : g_wd
    localparam int unsigned WD_BITS = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_BITS-1:0] r_wd;
    logic [WD_BITS-1:0] w_wd_inc;

    assign w_wd_inc = r_wd + WD_BITS'(1);
    assign w_wd_hit = (r_state == S_RUN) && (w_wd_inc == WD_BITS'(WATCHDOG_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wd <= '0;
      end else if (w_accept) begin
        r_wd <= '0;
      end else if (r_state == S_RUN) begin
        r_wd <= w_wd_inc;
      end
    end
  end else begin : g_no_wd
    assign w_wd_hit = 1'b0;
  end

`ifdef LAUNCH_CYCLE_COUNTER_EN
  logic [CYCLE_BITS-1:0] r_cycles;

  // Counts cycles with gpu_start high; saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if ((r_state == S_RUN) && (r_cycles != '1)) begin
      r_cycles <= r_cycles + CYCLE_BITS'(1);
    end
  end

  assign status_cycles = r_cycles;
`else
  assign status_cycles = '0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_count_nxt   = r_count;
    w_timeout_nxt = r_timeout;
    w_kill_pulse  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_count_nxt   = launch_thread_count;
          w_rst_cnt_nxt = '0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = (launch_thread_count != '0) ? S_RST : S_REPORT;
        end
      end
      S_RST: begin
        if (r_rst_cnt == RST_BITS'(RESET_CYCLES - 1)) begin
          w_state_nxt = S_DCR;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_BITS'(1);
        end
      end
      S_DCR: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // done has priority over a same-cycle watchdog expiry
        if (gpu_done) begin
          w_state_nxt   = S_REPORT;
          w_timeout_nxt = 1'b0;
        end else if (w_wd_hit) begin
          w_state_nxt   = S_REPORT;
          w_timeout_nxt = 1'b1;
          w_kill_pulse  = 1'b1;
        end
      end
      S_REPORT: begin
        if (r_status_valid && status_ready) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_gpu_reset_nxt = (w_state_nxt == S_RST) || w_kill_pulse;
    w_dcr_we_nxt    = (w_state_nxt == S_DCR);
    w_dcr_data_nxt  = w_dcr_we_nxt ? w_count_nxt : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rst_cnt      <= '0;
      r_count        <= '0;
      r_launch_ready <= 1'b0;
      r_gpu_reset    <= 1'b0;
      r_dcr_we       <= 1'b0;
      r_dcr_data     <= '0;
      r_gpu_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_status_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rst_cnt      <= w_rst_cnt_nxt;
      r_count        <= w_count_nxt;
      r_launch_ready <= (w_state_nxt == S_IDLE);
      r_gpu_reset    <= w_gpu_reset_nxt;
      r_dcr_we       <= w_dcr_we_nxt;
      r_dcr_data     <= w_dcr_data_nxt;
      r_gpu_start    <= (w_state_nxt == S_RUN);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_status_valid <= (w_state_nxt == S_REPORT);
      r_timeout      <= w_timeout_nxt;
    end
  end

  assign launch_ready                = r_launch_ready;
  assign gpu_reset                   = r_gpu_reset;
  assign device_control_write_enable = r_dcr_we;
  assign device_control_data         = r_dcr_data;
  assign gpu_start                   = r_gpu_start;
  assign status_busy                 = r_busy;
  assign status_valid                = r_status_valid;
  assign status_timeout              = r_timeout;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Randomized self-checking bench for gpu_launch_ctrl with a timeline-based launch model.
module tb_gpu_launch_ctrl;

  localparam int unsigned TCB = 8;
  localparam int unsigned RC  = 2;
  localparam int unsigned WD  = 50;
  localparam int unsigned CB  = 32;
`ifdef LAUNCH_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           launch_valid;
  logic           launch_ready;
  logic [TCB-1:0] launch_thread_count;
  logic           gpu_reset;
  logic           device_control_write_enable;
  logic [TCB-1:0] device_control_data;
  logic           gpu_start;
  logic           gpu_done;
  logic           status_busy;
  logic           status_valid;
  logic           status_ready;
  logic           status_timeout;
  logic [CB-1:0]  status_cycles;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  gpu_launch_ctrl #(
    .THREAD_COUNT_BITS(TCB),
    .RESET_CYCLES     (RC),
    .WATCHDOG_CYCLES  (WD),
    .CYCLE_BITS       (CB)
  ) u_dut (
    .clk                        (clk),
    .reset                      (reset),
    .launch_valid               (launch_valid),
    .launch_ready               (launch_ready),
    .launch_thread_count        (launch_thread_count),
    .gpu_reset                  (gpu_reset),
    .device_control_write_enable(device_control_write_enable),
    .device_control_data        (device_control_data),
    .gpu_start                  (gpu_start),
    .gpu_done                   (gpu_done),
    .status_busy                (status_busy),
    .status_valid               (status_valid),
    .status_ready               (status_ready),
    .status_timeout             (status_timeout),
    .status_cycles              (status_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {gpu_reset, dcr_we, start, valid, busy, launch_ready, dcr_data}
  function automatic logic [13:0] ctl_vec();
    return {gpu_reset, device_control_write_enable, gpu_start, status_valid,
            status_busy, launch_ready, device_control_data};
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({status_cycles, status_timeout, status_valid, status_busy, gpu_start,
                device_control_data, device_control_write_enable, gpu_reset, launch_ready});
  endfunction

  // One launch. k = run cycle (1-based) in which the GPU raises done, 0 = never.
  task automatic run_launch(input logic [TCB-1:0] count, input int k, input int hold,
                            input bit keep, input logic [TCB-1:0] next_count);
    int n;
    int vidx;
    int r;
    bit to;
    logic e_rst, e_we, e_start, e_valid;
    logic [13:0] ev;
    logic [63:0] exp_cycles;

    check("launch_ready_idle", 64'(launch_ready), 64'd1);
    launch_valid        = 1'b1;
    launch_thread_count = count;
    @(posedge clk);

    if (count == '0) begin
      n = 0; to = 1'b0; vidx = 1;
    end else begin
      if (k != 0 && k <= int'(WD)) begin
        n = k; to = 1'b0;
      end else begin
        n = int'(WD); to = 1'b1;
      end
      vidx = int'(RC) + 2 + n;
    end
    exp_cycles = CYC_EN ? 64'(n) : 64'd0;

    for (int i = 1; i <= vidx + hold; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (keep) launch_thread_count = next_count;
        else      launch_valid = 1'b0;
      end
      if (count == '0) begin
        e_rst = 1'b0; e_we = 1'b0; e_start = 1'b0; e_valid = 1'b1;
      end else begin
        e_rst   = (i <= int'(RC)) || (to && i == vidx);
        e_we    = (i == int'(RC) + 1);
        e_start = (i >= int'(RC) + 2) && (i < vidx);
        e_valid = (i >= vidx);
      end
      ev = {e_rst, e_we, e_start, e_valid, 1'b1, 1'b0, (e_we ? count : 8'h00)};
      check($sformatf("seq cnt=%0d k=%0d c%0d", count, k, i), 64'(ctl_vec()), 64'(ev));
      if (e_valid) begin
        check($sformatf("timeout cnt=%0d k=%0d c%0d", count, k, i), 64'(status_timeout), 64'(to));
        check($sformatf("cycles cnt=%0d k=%0d c%0d", count, k, i), 64'(status_cycles), exp_cycles);
      end
      r = i - (int'(RC) + 1);
      gpu_done     = e_start ? (r == k) : 1'($urandom);
      status_ready = (i < vidx) ? 1'($urandom) : (i == vidx + hold);
    end

    @(posedge clk);
    @(negedge clk);
    status_ready = 1'b0;
    gpu_done     = 1'b0;
    check($sformatf("post_handshake cnt=%0d", count), 64'(ctl_vec()), 64'(14'b00000100000000));
  endtask

  function automatic logic [TCB-1:0] gen_count();
    if ($urandom_range(0, 3) == 0) return '0;
    return TCB'($urandom);
  endfunction

  function automatic int gen_k();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return int'(WD) - 1;
      2:       return int'(WD);
      3:       return int'(WD) + 1;
      default: return int'($urandom_range(1, WD + 5));
    endcase
  endfunction

  initial begin
    logic [TCB-1:0] c_cur;
    logic [TCB-1:0] c_nxt;
    int             k;
    bit             keep;

    reset               = 1'b0;
    launch_valid        = 1'b0;
    launch_thread_count = '0;
    gpu_done            = 1'b0;
    status_ready        = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_out(), 64'd1);

    run_launch(8'd8, 21, 0, 1'b0, 8'd0);   // basic
    run_launch(8'd0, 0, 2, 1'b0, 8'd0);    // zero threads
    run_launch(8'd5, 0, 1, 1'b0, 8'd0);    // watchdog
    run_launch(8'd5, 50, 0, 1'b0, 8'd0);   // done on expiry cycle
    run_launch(8'd3, 10, 10, 1'b1, 8'd8);  // backpressure with launch_valid held
    run_launch(8'd8, 21, 0, 1'b0, 8'd0);

    // Reset five cycles into RUN
    launch_valid        = 1'b1;
    launch_thread_count = 8'd77;
    @(posedge clk);
    @(negedge clk);
    launch_valid = 1'b0;
    repeat (RC + 5) @(negedge clk);
    check("start_before_reset", 64'(gpu_start), 64'd1);
    reset = 1'b1;
    #1 check("mid_run_reset_outputs", all_out(), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("held_reset_outputs", all_out(), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("release_outputs", all_out(), 64'd1);
    run_launch(8'd8, 21, 0, 1'b0, 8'd0);

    c_cur = gen_count();
    for (int j = 0; j < 40; j++) begin
      c_nxt = gen_count();
      k     = gen_k();
      keep  = ($urandom_range(0, 2) == 0) && (j != 39);
      run_launch(c_cur, k, int'($urandom_range(0, 3)), keep, c_nxt);
      c_cur = c_nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
